mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DM_BURST, default 4: consecutive data grants allowed while fetch waits.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ifReq  input  1  instruction fetch request, held until ifReady.
REQ-006 ifAddress  input  ADDR_W  fetch address (the pc value).
REQ-007 ifReady  output  1  one-cycle pulse: ifData valid.
REQ-008 ifData  output  32  fetched instruction.
REQ-009 dmRead  input  1  data load request, held until dmReady.
REQ-010 dmWrite  input  1  data store request, held until dmReady.
REQ-011 dmAddress  input  ADDR_W  data address (the EX/MEM ALU result).
REQ-012 dmWriteData  input  32  store data.
REQ-013 dmReady  output  1  one-cycle pulse: access complete, dmReadData valid on loads.
REQ-014 dmReadData  output  32  load data.
REQ-015 memReq  output  1  request to the shared single-port memory.
REQ-016 memWe  output  1  write enable qualifying memReq.
REQ-017 memAddress  output  ADDR_W  shared memory address.
REQ-018 memWriteData  output  32  shared memory write data.
REQ-019 memAck  input  1  one-cycle completion from memory, arriving 1 or more cycles after memReq rises.
REQ-020 memReadData  input  32  read data, valid with memAck.
REQ-021 stallIF  output  1  combinational: ifReq && !ifReady; drives the PC and IF/ID stall.
REQ-022 stallMEM  output  1  combinational: (dmRead||dmWrite) && !dmReady; freezes the whole pipeline.

Function
REQ-023 The FSM SHALL have four states: IDLE, IF_BUSY, DM_BUSY, DONE.
REQ-024 From IDLE, a data request SHALL win over ifReq, unless the burst counter equals MAX_DM_BURST and ifReq is high; IF then wins.
REQ-025 On a grant, the block SHALL register the address, the write data and memWe (dmWrite) and move to the busy state; memReq SHALL be high from the next cycle.
REQ-026 In a busy state, memReq, memWe, memAddress and memWriteData SHALL hold stable until memAck.
REQ-027 On memAck, the block SHALL latch memReadData into ifData or dmReadData per the grant, drop memReq, and enter DONE.
REQ-028 In DONE, exactly one of ifReady or dmReady SHALL be high for one cycle; then the FSM SHALL return to IDLE.
REQ-029 No arbitration SHALL occur in DONE, so a request still high during its own ready cycle is not re-granted.
REQ-030 Latency: a request seen in IDLE at cycle N with memAck at cycle M SHALL give ready at M+1; the minimum is N+3.
REQ-031 When dmRead and dmWrite are both high, the access SHALL be a write.
REQ-032 memAck in IDLE or DONE SHALL be ignored: no state change and no ready pulse.
REQ-033 On a stall-free store, dmReadData SHALL keep its previous value.
REQ-034 Burst counter: increments on each DM grant made while ifReq is high, saturates at MAX_DM_BURST, and clears on any IF grant or when a DM grant is made with ifReq low.

Reset
REQ-035 While reset is high: state IDLE; memReq, memWe, ifReady, dmReady = 0; memAddress, memWriteData, ifData, dmReadData = 0; burst counter = 0.
REQ-036 Reset mid-access SHALL abandon the transaction with no ready pulse; a later stale memAck SHALL be ignored per REQ-032.

Structure
REQ-037 The state encodings and the default MAX_DM_BURST SHALL sit in a shared include header with the pipeline constants.
REQ-038 One sub-module SHALL exist: arb_priority, combinational, taking the requests and the burst-saturate flag and returning the grant.

Verification
REQ-039 Fetch only: ifReq=1, ifAddress=0x40, memAck 2 cycles after memReq, memReadData=0x8C080004 -> ifReady pulses once with ifData=0x8C080004; stallIF=1 until then.
REQ-040 Simultaneous: ifReq and dmRead both high in IDLE -> DM served first (memAddress=dmAddress); IF is served next, with memReq rising one cycle after DONE.
REQ-041 Starvation: dmRead held continuously, ifReq high, MAX_DM_BURST=4 -> the 5th grant goes to IF.
REQ-042 Store: dmWrite=1, dmAddress=0x10, dmWriteData=0xDEADBEEF -> memWe=1 with those values stable until memAck; dmReady pulses once.
REQ-043 Reset mid-access: assert reset while memReq=1, then memAck after release -> no ready pulse, all outputs 0, FSM in IDLE.
REQ-044 Both dmRead and dmWrite high -> memWe=1 (write).

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and constants for the instruction/data memory
//            arbiter (state encodings, grant encoding, default limits).
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Consecutive data grants tolerated while a fetch is waiting
    localparam int C_MAX_DM_BURST_DEFAULT = 4;
    // Address width of the pipeline's memory ports
    localparam int C_ADDR_W_DEFAULT       = 32;
    // Instruction / data word width
    localparam int C_DATA_W               = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        DONE    = 2'd3
    } arbState_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_IF   = 2'd1,
        GRANT_DM   = 2'd2
    } grant_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_arb_priority.sv
`default_nettype none
// ============================================================================
// Module   : arb_priority
// Brief    : Combinational priority pick between fetch and data requests.
//            Data wins unless the burst limit is reached with a fetch pending.
// Revision : 1.0 - initial release
// ============================================================================
module arb_priority
    import mem_arbiter_pkg::*;
(
    input  logic   i_ifReq,
    input  logic   i_dmReq,
    input  logic   i_burstSat,
    output grant_t o_grant
);

    // Data first, but a saturated burst hands the slot to the waiting fetch
    always_comb begin
        o_grant = GRANT_NONE;
        if (i_dmReq && !(i_burstSat && i_ifReq)) begin
            o_grant = GRANT_DM;
        end else if (i_ifReq) begin
            o_grant = GRANT_IF;
        end
    end

endmodule : arb_priority
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-port memory between instruction fetch and
//            data access. One transaction at a time; data has priority with
//            a burst limit so fetch cannot starve.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DM_BURST = C_MAX_DM_BURST_DEFAULT,
    parameter int ADDR_W       = C_ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifReq,
    input  logic [ADDR_W-1:0]   ifAddress,
    output logic                ifReady,
    output logic [C_DATA_W-1:0] ifData,
    input  logic                dmRead,
    input  logic                dmWrite,
    input  logic [ADDR_W-1:0]   dmAddress,
    input  logic [C_DATA_W-1:0] dmWriteData,
    output logic                dmReady,
    output logic [C_DATA_W-1:0] dmReadData,
    output logic                memReq,
    output logic                memWe,
    output logic [ADDR_W-1:0]   memAddress,
    output logic [C_DATA_W-1:0] memWriteData,
    input  logic                memAck,
    input  logic [C_DATA_W-1:0] memReadData,
    output logic                stallIF,
    output logic                stallMEM
);

    localparam int                 c_CNT_W     = $clog2(MAX_DM_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(MAX_DM_BURST);

    arbState_t             r_state;
    arbState_t             w_nextState;
    grant_t                w_grant;
    logic                  w_dmReq;
    logic                  w_burstSat;
    logic [c_CNT_W-1:0]    r_burstCnt;
    logic                  r_memReq;
    logic                  r_memWe;
    logic [ADDR_W-1:0]     r_memAddress;
    logic [C_DATA_W-1:0]   r_memWriteData;
    logic [C_DATA_W-1:0]   r_ifData;
    logic [C_DATA_W-1:0]   r_dmReadData;
    logic                  r_ifReady;
    logic                  r_dmReady;

    assign w_dmReq    = dmRead || dmWrite;
    assign w_burstSat = (r_burstCnt == c_BURST_MAX);

    arb_priority u_arbPriority (
        .i_ifReq    (ifReq),
        .i_dmReq    (w_dmReq),
        .i_burstSat (w_burstSat),
        .o_grant    (w_grant)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: arbitrate only in IDLE, wait for memAck while busy
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant == GRANT_DM) begin
                    w_nextState = DM_BUSY;
                end else if (w_grant == GRANT_IF) begin
                    w_nextState = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (memAck) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Memory-side request registers, returned data and ready pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memReq       <= 1'b0;
            r_memWe        <= 1'b0;
            r_memAddress   <= '0;
            r_memWriteData <= '0;
            r_ifData       <= '0;
            r_dmReadData   <= '0;
            r_ifReady      <= 1'b0;
            r_dmReady      <= 1'b0;
        end else begin
            r_ifReady <= 1'b0;
            r_dmReady <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant == GRANT_DM) begin
                        r_memReq       <= 1'b1;
                        r_memWe        <= dmWrite;
                        r_memAddress   <= dmAddress;
                        r_memWriteData <= dmWriteData;
                    end else if (w_grant == GRANT_IF) begin
                        r_memReq       <= 1'b1;
                        r_memWe        <= 1'b0;
                        r_memAddress   <= ifAddress;
                        r_memWriteData <= '0;
                    end
                end
                IF_BUSY: begin
                    if (memAck) begin
                        r_ifData  <= memReadData;
                        r_memReq  <= 1'b0;
                        r_ifReady <= 1'b1;
                    end
                end
                DM_BUSY: begin
                    if (memAck) begin
                        // Stores leave the last load result untouched
                        if (!r_memWe) begin
                            r_dmReadData <= memReadData;
                        end
                        r_memReq  <= 1'b0;
                        r_dmReady <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Burst counter: counts data grants that made a pending fetch wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burstCnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant == GRANT_DM) begin
                if (!ifReq) begin
                    r_burstCnt <= '0;
                end else if (!w_burstSat) begin
                    r_burstCnt <= r_burstCnt + 1'b1;
                end
            end else if (w_grant == GRANT_IF) begin
                r_burstCnt <= '0;
            end
        end
    end

    assign memReq       = r_memReq;
    assign memWe        = r_memWe;
    assign memAddress   = r_memAddress;
    assign memWriteData = r_memWriteData;
    assign ifData       = r_ifData;
    assign dmReadData   = r_dmReadData;
    assign ifReady      = r_ifReady;
    assign dmReady      = r_dmReady;
    assign stallIF      = ifReq && !r_ifReady;
    assign stallMEM     = w_dmReq && !r_dmReady;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter: a vector table of
//            single transactions plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReq;
    logic [31:0] ifAddress;
    logic        ifReady;
    logic [31:0] ifData;
    logic        dmRead;
    logic        dmWrite;
    logic [31:0] dmAddress;
    logic [31:0] dmWriteData;
    logic        dmReady;
    logic [31:0] dmReadData;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memAck;
    logic [31:0] memReadData;
    logic        stallIF;
    logic        stallMEM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DM_BURST(4), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ifReq        (ifReq),
        .ifAddress    (ifAddress),
        .ifReady      (ifReady),
        .ifData       (ifData),
        .dmRead       (dmRead),
        .dmWrite      (dmWrite),
        .dmAddress    (dmAddress),
        .dmWriteData  (dmWriteData),
        .dmReady      (dmReady),
        .dmReadData   (dmReadData),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memAck       (memAck),
        .memReadData  (memReadData),
        .stallIF      (stallIF),
        .stallMEM     (stallMEM)
    );

    typedef struct {
        logic        ifReq;
        logic        dmRead;
        logic        dmWrite;
        logic [31:0] ifAddr;
        logic [31:0] dmAddr;
        logic [31:0] wData;
        logic [31:0] rData;
        int          ackDly;
        logic [31:0] expAddr;
        logic        expWe;
        logic        expIsDm;
        logic [31:0] expIfData;
        logic [31:0] expDmData;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dropReqs;
        ifReq   = 1'b0;
        dmRead  = 1'b0;
        dmWrite = 1'b0;
    endtask

    // One transaction from IDLE: grant, hold while busy, ack, ready pulse
    task automatic runTxn(input vec_t v, input int idx);
        ifReq       = v.ifReq;
        dmRead      = v.dmRead;
        dmWrite     = v.dmWrite;
        ifAddress   = v.ifAddr;
        dmAddress   = v.dmAddr;
        dmWriteData = v.wData;
        #1;
        chk($sformatf("v%0d idle memReq", idx), {31'd0, memReq}, 32'd0);
        tick;
        chk($sformatf("v%0d memReq", idx), {31'd0, memReq}, 32'd1);
        chk($sformatf("v%0d memAddress", idx), memAddress, v.expAddr);
        chk($sformatf("v%0d memWe", idx), {31'd0, memWe}, {31'd0, v.expWe});
        if (v.expWe) chk($sformatf("v%0d memWriteData", idx), memWriteData, v.wData);
        if (v.expIsDm) chk($sformatf("v%0d stallMEM", idx), {31'd0, stallMEM}, 32'd1);
        else           chk($sformatf("v%0d stallIF", idx), {31'd0, stallIF}, 32'd1);
        for (int d = 1; d < v.ackDly; d++) begin
            tick;
            chk($sformatf("v%0d hold memReq c%0d", idx, d), {31'd0, memReq}, 32'd1);
            chk($sformatf("v%0d hold memAddress c%0d", idx, d), memAddress, v.expAddr);
            chk($sformatf("v%0d hold memWe c%0d", idx, d), {31'd0, memWe}, {31'd0, v.expWe});
            if (v.expWe) chk($sformatf("v%0d hold memWriteData c%0d", idx, d), memWriteData, v.wData);
            chk($sformatf("v%0d early ready c%0d", idx, d), {30'd0, ifReady, dmReady}, 32'd0);
        end
        tick;
        memAck      = 1'b1;
        memReadData = v.rData;
        tick;
        memAck      = 1'b0;
        memReadData = 32'h0BAD0BAD;
        chk($sformatf("v%0d ready", idx), {30'd0, ifReady, dmReady},
            v.expIsDm ? 32'd1 : 32'd2);
        chk($sformatf("v%0d done memReq", idx), {31'd0, memReq}, 32'd0);
        chk($sformatf("v%0d ifData", idx), ifData, v.expIfData);
        chk($sformatf("v%0d dmReadData", idx), dmReadData, v.expDmData);
        if (v.expIsDm) chk($sformatf("v%0d stallMEM done", idx), {31'd0, stallMEM}, 32'd0);
        else           chk($sformatf("v%0d stallIF done", idx), {31'd0, stallIF}, 32'd0);
        dropReqs();
        tick;
        chk($sformatf("v%0d ready drops", idx), {30'd0, ifReady, dmReady}, 32'd0);
        chk($sformatf("v%0d idle after", idx), {31'd0, memReq}, 32'd0);
    endtask

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            if dr dw ifAddr        dmAddr        wData         rData         dly expAddr    we dm expIfData     expDmData
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8C080004, 2, 32'h40, 1'b0, 1'b0, 32'h8C080004, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'h12345678, 1, 32'h20, 1'b0, 1'b1, 32'h8C080004, 32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 32'hAAAA5555, 3, 32'h10, 1'b1, 1'b1, 32'h8C080004, 32'h12345678};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h14, 32'hCAFEF00D, 32'h5A5A5A5A, 1, 32'h14, 1'b1, 1'b1, 32'h8C080004, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h00000013, 1, 32'h44, 1'b0, 1'b0, 32'h00000013, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h24, 32'h0, 32'hFFFF0000, 4, 32'h24, 1'b0, 1'b1, 32'h00000013, 32'hFFFF0000};

        reset       = 1'b1;
        dropReqs();
        ifAddress   = '0;
        dmAddress   = '0;
        dmWriteData = '0;
        memAck      = 1'b0;
        memReadData = '0;
        repeat (3) tick;
        chk("reset memReq/memWe", {30'd0, memReq, memWe}, 32'd0);
        chk("reset ready", {30'd0, ifReady, dmReady}, 32'd0);
        chk("reset memAddress", memAddress, 32'd0);
        chk("reset memWriteData", memWriteData, 32'd0);
        chk("reset ifData", ifData, 32'd0);
        chk("reset dmReadData", dmReadData, 32'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            runTxn(vecs[i], i);
        end

        // Simultaneous requests: data first, fetch right after
        ifReq = 1'b1; ifAddress = 32'h80; dmRead = 1'b1; dmAddress = 32'h30;
        tick;
        chk("sim first addr", memAddress, 32'h30);
        chk("sim first we", {31'd0, memWe}, 32'd0);
        chk("sim stalls", {30'd0, stallIF, stallMEM}, 32'd3);
        tick;
        memAck = 1'b1; memReadData = 32'h11112222;
        tick;
        memAck = 1'b0;
        chk("sim dm ready", {30'd0, ifReady, dmReady}, 32'd1);
        chk("sim dmReadData", dmReadData, 32'h11112222);
        dmRead = 1'b0;
        tick;
        chk("sim idle gap memReq", {31'd0, memReq}, 32'd0);
        chk("sim idle stallIF", {31'd0, stallIF}, 32'd1);
        tick;
        chk("sim second memReq", {31'd0, memReq}, 32'd1);
        chk("sim second addr", memAddress, 32'h80);
        tick;
        memAck = 1'b1; memReadData = 32'h33334444;
        tick;
        memAck = 1'b0;
        chk("sim if ready", {30'd0, ifReady, dmReady}, 32'd2);
        chk("sim ifData", ifData, 32'h33334444);
        dropReqs();
        tick;

        // Starvation guard: four data grants, then the fetch gets the fifth
        ifReq = 1'b1; ifAddress = 32'h100; dmRead = 1'b1; dmAddress = 32'h200;
        for (int g = 1; g <= 5; g++) begin
            tick;
            chk($sformatf("burst grant %0d addr", g), memAddress, (g < 5) ? 32'h200 : 32'h100);
            tick;
            memAck = 1'b1; memReadData = 32'h0000_0100 + 32'(g);
            tick;
            memAck = 1'b0;
            chk($sformatf("burst grant %0d ready", g), {30'd0, ifReady, dmReady},
                (g < 5) ? 32'd1 : 32'd2);
            if (g == 5) dropReqs();
            tick;
        end
        chk("burst ifData", ifData, 32'h00000105);
        chk("burst dmReadData", dmReadData, 32'h00000104);

        // Stray memAck while idle must do nothing
        memAck = 1'b1; memReadData = 32'h77777777;
        tick;
        memAck = 1'b0;
        chk("stray ack memReq", {31'd0, memReq}, 32'd0);
        chk("stray ack ready", {30'd0, ifReady, dmReady}, 32'd0);
        tick;
        chk("stray ack ready later", {30'd0, ifReady, dmReady}, 32'd0);
        chk("stray ack data", dmReadData, 32'h00000104);

        // Reset in the middle of an access, stale ack afterwards
        dmRead = 1'b1; dmAddress = 32'h44;
        tick;
        chk("rst mid memReq before", {31'd0, memReq}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst mid async memReq", {31'd0, memReq}, 32'd0);
        dropReqs();
        tick;
        reset = 1'b0;
        tick;
        memAck = 1'b1; memReadData = 32'h99999999;
        tick;
        memAck = 1'b0;
        chk("rst mid ready", {30'd0, ifReady, dmReady}, 32'd0);
        chk("rst mid memReq/memWe", {30'd0, memReq, memWe}, 32'd0);
        chk("rst mid memAddress", memAddress, 32'd0);
        chk("rst mid memWriteData", memWriteData, 32'd0);
        chk("rst mid ifData", ifData, 32'd0);
        chk("rst mid dmReadData", dmReadData, 32'd0);
        tick;
        chk("rst mid ready later", {30'd0, ifReady, dmReady}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
